// File: rtl/toggle_activity_monitor.sv
// rtl/toggle_activity_monitor.sv - bit-toggle activity counter over fixed windows of valid samples
//
// Counts bit toggles between consecutive valid samples of din. After WIN
// counted transitions the window total is presented on res_count/res_valid
// and is held until the consumer takes it with res_ready.
//
// Optional feature macro: ACT_PEAK_EN (builds the peak_count tracker;
// otherwise peak_count is tied to 0).
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-low reset
//   start      - pulse, begins a measurement (accepted only while idle)
//   stop       - pulse, aborts a measurement (wins over start)
//   din        - observed bus
//   din_valid  - sample qualifier for din
//   res_count  - toggle count of the last completed window
//   res_valid  - res_count valid
//   res_ready  - consumer accepts res_count when res_valid & res_ready
//   busy       - 1 while armed or counting
//   ovr        - sticky: a pending result was overwritten
//   win_idx    - completed windows since start, wraps
//   peak_count - largest res_count since start (0 without ACT_PEAK_EN)

module toggle_activity_monitor #(
   parameter int DW  = 16,
   parameter int WIN = 64,
   parameter int CW  = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic [DW-1:0] din,
   input  logic          din_valid,
   output logic [CW-1:0] res_count,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          busy,
   output logic          ovr,
   output logic [7:0]    win_idx,
   output logic [CW-1:0] peak_count
);

   localparam int NW = (WIN > 2) ? $clog2(WIN) : 1;
   localparam logic [NW-1:0] N_LAST = NW'(WIN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] acc;
   logic [NW-1:0] n;
   logic [DW-1:0] prev;

   logic [CW-1:0] toggles;
   logic [CW:0]   sum_wide;
   logic [CW-1:0] acc_next;
   logic          win_done;
   logic          start_ok;

   function automatic logic [CW-1:0] popcount(input logic [DW-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < DW; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   always_comb begin
      toggles  = popcount(din ^ prev);
      sum_wide = {1'b0, acc} + {1'b0, toggles};
      // Saturate rather than wrap so an undersized CW reads as "full".
      acc_next = sum_wide[CW] ? {CW{1'b1}} : sum_wide[CW-1:0];
      win_done = (state == COUNT) && din_valid && !stop && (n == N_LAST);
      start_ok = (state == IDLE) && start && !stop;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         acc       <= '0;
         n         <= '0;
         prev      <= '0;
         res_count <= '0;
         res_valid <= 1'b0;
         ovr       <= 1'b0;
         win_idx   <= 8'd0;
      end else begin
         // Consumer handshake; a result load below overrides this clear.
         if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start_ok) begin
                  state   <= ARM;
                  busy    <= 1'b1;
                  acc     <= '0;
                  n       <= '0;
                  ovr     <= 1'b0;
                  win_idx <= 8'd0;
               end
            end

            ARM: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (din_valid) begin
                  // First sample only seeds the reference value.
                  prev  <= din;
                  state <= COUNT;
               end
            end

            COUNT: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  acc   <= '0;
                  n     <= '0;
               end else if (din_valid) begin
                  prev <= din;
                  if (win_done) begin
                     res_count <= acc_next;
                     res_valid <= 1'b1;
                     acc       <= '0;
                     n         <= '0;
                     win_idx   <= win_idx + 8'd1;
                     if (res_valid && !res_ready) begin
                        ovr <= 1'b1;
                     end
                  end else begin
                     acc <= acc_next;
                     n   <= n + 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ACT_PEAK_EN
   logic [CW-1:0] peak_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         peak_q <= '0;
      end else if (start_ok) begin
         peak_q <= '0;
      end else if (win_done && (acc_next > peak_q)) begin
         peak_q <= acc_next;
      end
   end

   assign peak_count = peak_q;
`else
   assign peak_count = '0;
`endif

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// tb/tb_toggle_activity_monitor.sv - self-checking bench for toggle_activity_monitor

module tb_toggle_activity_monitor;

   localparam int DW  = 16;
   localparam int WIN = 4;
   localparam int CW  = 24;
   localparam int NR  = 300;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stop;
   logic [DW-1:0] din;
   logic          din_valid;
   logic [CW-1:0] res_count;
   logic          res_valid;
   logic          res_ready;
   logic          busy;
   logic          ovr;
   logic [7:0]    win_idx;
   logic [CW-1:0] peak_count;

   int n_assert = 0;
   int n_fail   = 0;

   toggle_activity_monitor #(.DW(DW), .WIN(WIN), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .din        (din),
      .din_valid  (din_valid),
      .res_count  (res_count),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .busy       (busy),
      .ovr        (ovr),
      .win_idx    (win_idx),
      .peak_count (peak_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp(input logic [DW-1:0] d);
      din       = d;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
   endtask

   task automatic gap(input logic [DW-1:0] junk);
      din       = junk;
      din_valid = 1'b0;
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   logic [DW-1:0] rd [NR];
   logic          rv [NR];
   logic [DW-1:0] samples [$];
   int            exp_q [$];
   int            got_q [$];
   int            nwin;
   int            s;
   logic [CW-1:0] exp_peak;

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0;
      din = '0; din_valid = 1'b0; res_ready = 1'b0;
      tick(); tick();
      chk("reset_res_count", 32'(res_count), 32'd0);
      chk("reset_res_valid", 32'(res_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ovr", 32'(ovr), 32'd0);
      chk("reset_win_idx", 32'(win_idx), 32'd0);
      chk("reset_peak", 32'(peak_count), 32'd0);
      rst = 1'b1;
      tick();

      // Alternating full-bus toggles: 4 transitions x 16 bits
      pulse_start();
      chk("t1_busy", 32'(busy), 32'd1);
      smp(16'h0000); smp(16'hFFFF); smp(16'h0000); smp(16'hFFFF);
      chk("t1_not_yet", 32'(res_valid), 32'd0);
      smp(16'h0000);
      chk("t1_valid", 32'(res_valid), 32'd1);
      chk("t1_count", 32'(res_count), 32'd64);
      chk("t1_win_idx", 32'(win_idx), 32'd1);
      pulse_start();
      chk("t1_start_busy_ignored", 32'(win_idx), 32'd1);
      res_ready = 1'b1;
      tick();
      chk("t1_accept", 32'(res_valid), 32'd0);

      // Constant bus gives zero toggles
      pulse_stop();
      chk("t2_stop_busy", 32'(busy), 32'd0);
      pulse_start();
      for (int i = 0; i < WIN + 1; i++) smp(16'h1234);
      chk("t2_valid", 32'(res_valid), 32'd1);
      chk("t2_count", 32'(res_count), 32'd0);
      tick();

      // Invalid cycles with junk din must not count
      pulse_stop();
      pulse_start();
      smp(16'h0001); gap(16'hA5A5);
      smp(16'h0003); gap(16'h5A5A); gap(16'hFFFF);
      smp(16'h0002); smp(16'h0000); gap(16'h1357);
      smp(16'h0001);
      chk("t3_valid", 32'(res_valid), 32'd1);
      chk("t3_count", 32'(res_count), 32'd4);
      tick();

      // Overwrite while consumer stalls
      res_ready = 1'b0;
      pulse_stop();
      pulse_start();
      smp(16'h0000); smp(16'h00FF); smp(16'h0000); smp(16'h00FF); smp(16'h0000);
      chk("t4_first", 32'(res_count), 32'd32);
      chk("t4_no_ovr_yet", 32'(ovr), 32'd0);
      smp(16'h000F); smp(16'h0000); smp(16'h000F); smp(16'h0000);
      chk("t4_ovr", 32'(ovr), 32'd1);
      chk("t4_valid", 32'(res_valid), 32'd1);
      chk("t4_count", 32'(res_count), 32'd16);
      pulse_stop();
      chk("t4_stop_busy", 32'(busy), 32'd0);
      chk("t4_pending_after_stop", 32'(res_valid), 32'd1);
      pulse_start();
      chk("t4_start_clears_ovr", 32'(ovr), 32'd0);
      chk("t4_start_clears_idx", 32'(win_idx), 32'd0);
      chk("t4_pending_after_start", 32'(res_valid), 32'd1);
      chk("t4_pending_count", 32'(res_count), 32'd16);
      res_ready = 1'b1;
      tick();
      chk("t4_accept", 32'(res_valid), 32'd0);

      // Stop after two transitions, then a clean restart
      smp(16'h0000); smp(16'hFFFF); smp(16'h0000);
      pulse_stop();
      chk("t5_stop_busy", 32'(busy), 32'd0);
      smp(16'hFFFF); smp(16'h0000); smp(16'hFFFF);
      chk("t5_idle_no_result", 32'(res_valid), 32'd0);
      chk("t5_idle_win_idx", 32'(win_idx), 32'd0);
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("t5_stop_beats_start", 32'(busy), 32'd0);
      pulse_start();
      smp(16'h0000); smp(16'hFFFF); smp(16'h0000); smp(16'hFFFF); smp(16'h0000);
      chk("t5_clean_count", 32'(res_count), 32'd64);
      chk("t5_clean_idx", 32'(win_idx), 32'd1);
      tick();

      // Peak: windows of 64 then 16
      smp(16'h000F); smp(16'h0000); smp(16'h000F); smp(16'h0000);
      chk("t6_count", 32'(res_count), 32'd16);
`ifdef ACT_PEAK_EN
      exp_peak = 24'd64;
`else
      exp_peak = 24'd0;
`endif
      chk("t6_peak", 32'(peak_count), 32'(exp_peak));
      tick();

      // Reset mid-window with a pending result
      res_ready = 1'b0;
      smp(16'hFFFF); smp(16'h0000); smp(16'hFFFF); smp(16'h0000);
      chk("t7_pending", 32'(res_valid), 32'd1);
      smp(16'hFFFF);
      rst = 1'b0;
      tick();
      chk("t7_res_count", 32'(res_count), 32'd0);
      chk("t7_res_valid", 32'(res_valid), 32'd0);
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_ovr", 32'(ovr), 32'd0);
      chk("t7_win_idx", 32'(win_idx), 32'd0);
      chk("t7_peak", 32'(peak_count), 32'd0);
      rst = 1'b1;
      tick();

      // Randomized run against window sums computed from the sample list
      for (int i = 0; i < NR; i++) begin
         rd[i] = DW'($urandom);
         rv[i] = ($urandom_range(0, 9) < 7);
         if (rv[i]) samples.push_back(rd[i]);
      end
      nwin = (samples.size() - 1) / WIN;
      for (int k = 0; k < nwin; k++) begin
         s = 0;
         for (int j = 1; j <= WIN; j++)
            s += $countones(samples[k*WIN + j] ^ samples[k*WIN + j - 1]);
         exp_q.push_back(s);
      end

      res_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < NR; i++) begin
         if (res_valid && res_ready) got_q.push_back(int'(res_count));
         din       = rd[i];
         din_valid = rv[i];
         tick();
      end
      din_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (res_valid && res_ready) got_q.push_back(int'(res_count));
         tick();
      end

      chk("rnd_num_results", 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
         chk($sformatf("rnd_window_%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
      chk("rnd_win_idx", 32'(win_idx), 32'(nwin % 256));
      chk("rnd_no_ovr", 32'(ovr), 32'd0);
      chk("rnd_busy", 32'(busy), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
